// File: rtl/bcd_pkg.sv
// Shared BCD types and FSM encoding for the binary-to-BCD front end
// and the downstream 2-digit BCD add/subtract stage.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd2_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } b2b_state_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// Shift-add-3 digit correction: a digit of 5 or more gets 3 added
// so that the following left shift carries cleanly into the next decade.
module bcd_add3
   import bcd_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   // The corrected digit is at most 12, so the 4-bit sum never carries out.
   assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle)
// with valid/ready handshakes on both sides and one conversion in flight.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH = 7
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_bcd,
   output logic             out_ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 12 + WIDTH;

   b2b_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   sr_q, sr_d;
   bcd2_t           out_bcd_q, out_bcd_d;
   logic            out_ovf_q, out_ovf_d;

   bcd_digit_t      hund, tens, units;
   bcd_digit_t      hund_c, tens_c, units_c;
   logic [SW-1:0]   corrected, shifted;

   // Shift register layout: {hund, tens, units, remaining binary bits}.
   assign hund  = sr_q[SW-1 -: 4];
   assign tens  = sr_q[SW-5 -: 4];
   assign units = sr_q[SW-9 -: 4];

   bcd_add3 u_add3_hund  (.d(hund),  .q(hund_c));
   bcd_add3 u_add3_tens  (.d(tens),  .q(tens_c));
   bcd_add3 u_add3_units (.d(units), .q(units_c));

   assign corrected = {hund_c, tens_c, units_c, sr_q[WIDTH-1:0]};
   assign shifted   = {corrected[SW-2:0], 1'b0};

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_bcd   = out_bcd_q;
   assign out_ovf   = out_ovf_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      out_bcd_d = out_bcd_q;
      out_ovf_d = out_ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = {{12{1'b0}}, in_bin};
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            sr_d  = shifted;
            cnt_d = cnt_q - CW'(1);
            // Last bit shifted in: the digit fields of the new value are final.
            if (cnt_q == CW'(1)) begin
               out_bcd_d = shifted[SW-5 -: 8];
               out_ovf_d = |shifted[SW-1 -: 4];
               state_d   = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath is cleared too so a dropped conversion leaves no residue.
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_q      <= '0;
         out_bcd_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         out_bcd_q <= out_bcd_d;
         out_ovf_q <= out_ovf_d;
      end
   end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed boundary cases plus
// exhaustive and randomized streams scored against an arithmetic model.
module tb_bin2bcd_seq;
   import bcd_pkg::*;

   localparam int W = 7;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_bin;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_bcd;
   logic         out_ovf;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits of v mod 100, packed as BCD.
   function automatic logic [7:0] ref_bcd(input int v);
      int t, u;
      t = (v % 100) / 10;
      u = v % 10;
      return 8'(t * 16 + u);
   endfunction

   function automatic logic ref_ovf(input int v);
      return v > 99;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // One directed conversion with latency, result and hand-back checks.
   task automatic convert(input int v, input string tag);
      int n;
      in_valid  = 1'b1;
      in_bin    = W'(v);
      out_ready = 1'b0;
      check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_bin   = W'($urandom);
      check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(W));
      check({tag, " bcd"}, 32'(out_bcd), 32'(ref_bcd(v)));
      check({tag, " ovf"}, 32'(out_ovf), 32'(ref_ovf(v)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   // Streams n_items values through the DUT, scoring every delivered result.
   task automatic run_stream(input int n_items, input bit rnd, input string tag);
      int q[$];
      int sent, got, cyc, next_v, exp_v;
      logic acc, dlv;
      sent   = 0;
      got    = 0;
      cyc    = 0;
      next_v = rnd ? int'($urandom_range(0, 127)) : 0;
      while (got < n_items && cyc < n_items * 16 + 64) begin
         in_valid  = (sent < n_items) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         in_bin    = in_valid ? W'(next_v) : W'($urandom);
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         acc = in_valid && in_ready;
         dlv = out_valid && out_ready;
         if (out_valid) begin
            if (out_bcd[7:4] > BCD_MAX || out_bcd[3:0] > BCD_MAX)
               check({tag, " nibble_range"}, 32'(out_bcd), 32'(ref_bcd(0)) | 32'hDEAD_0000);
         end
         if (dlv) begin
            if (q.size() == 0) begin
               check({tag, " spurious_result"}, 32'(out_bcd), 32'hFFFF_FFFF);
            end else begin
               exp_v = q.pop_front();
               check({tag, " bcd"}, 32'(out_bcd), 32'(ref_bcd(exp_v)));
               check({tag, " ovf"}, 32'(out_ovf), 32'(ref_ovf(exp_v)));
            end
            got++;
         end
         if (acc) begin
            q.push_back(next_v);
            sent++;
            next_v = rnd ? int'($urandom_range(0, 127)) : sent;
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({tag, " results_received"}, 32'(got), 32'(n_items));
      check({tag, " queue_drained"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] held_bcd;
      logic       held_ovf;
      int         n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_bin    = '0;
      out_ready = 1'b0;
      do_reset();

      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_bcd",   32'(out_bcd),   32'h00);
      check("reset out_ovf",   32'(out_ovf),   32'd0);

      convert(45,  "conv45");
      convert(0,   "conv0");
      convert(99,  "conv99");
      convert(100, "conv100");
      convert(127, "conv127");

      // Backpressure: DONE held with out_ready low while a new input is offered.
      in_valid = 1'b1;
      in_bin   = W'(63);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      check("bp reached_done", 32'(out_valid), 32'd1);
      held_bcd = out_bcd;
      held_ovf = out_ovf;
      check("bp result", 32'(held_bcd), 32'(ref_bcd(63)));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_bin   = W'($urandom);
         step();
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp out_bcd",   32'(out_bcd),   32'(held_bcd));
         check("bp out_ovf",   32'(out_ovf),   32'(held_ovf));
         check("bp in_ready",  32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready",  32'(in_ready),  32'd1);

      // Reset on the third SHIFT cycle of 88 must drop the conversion.
      in_valid = 1'b1;
      in_bin   = W'(88);
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst in_ready",  32'(in_ready),  32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst out_bcd",   32'(out_bcd),   32'h00);
      check("midrst out_ovf",   32'(out_ovf),   32'd0);
      n = 0;
      while (n < 12) begin
         step();
         check("midrst no_result", 32'(out_valid), 32'd0);
         n++;
      end
      convert(12, "after_rst12");

      run_stream(128, 1'b0, "exhaustive");
      run_stream(80,  1'b1, "random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bin2bcd_seq
